sb_trans_deframer: RTL and testbench
====================================

Name: sb_trans_deframer

Overview:
- Parametrised sideband receive deframer; next generation of the transactions FSM.
- Consumes the unstuffed-byte stream from the sideband RX symbol path.
- Recognises DLE-framed AT command/response frames, including DLE-DLE escaping inside the body, and LT (DLE LSE CLSE) frames.
- Checks length and CRC-16, buffers up to MAX_DATA_BYTES data bytes, and presents decoded transactions to the sideband control unit.

Parameters:
MAX_DATA_BYTES, 64, data-byte capacity of the frame buffer (1..127)
ADDR_W, 8, width of t_address (register address byte zero-extended)
IDX_W, 7, width of rd_idx; must satisfy 2**IDX_W >= MAX_DATA_BYTES

Ports:
sb_clk  in  1  sideband clock
rst  in  1  asynchronous, active-low reset
sbrx_valid  in  1  sbrx_data holds a received byte this cycle
sbrx_data  in  8  received byte
sbrx_error  in  1  symbol/parity error on current byte (qualified by sbrx_valid)
tconnect  in  1  link-up request
tdisconnect  in  1  link-down request
t_valid  out  1  one-cycle pulse: AT frame accepted
t_is_cmd  out  1  1 = command (STX 0x05), 0 = response (STX 0x04)
t_write  out  1  WnR bit (len byte bit 7)
t_address  out  ADDR_W  register address
t_len  out  7  length field (len byte bits 6:0)
rd_idx  in  IDX_W  buffer read index
rd_data  out  8  buffer byte at rd_idx, combinational read
lt_valid  out  1  one-cycle pulse: DLE LSE CLSE received
trans_error  out  1  one-cycle pulse: frame aborted with error
disconnect  out  1  level: block in DISCONNECT

Behaviour:
- Reset: state DISCONNECT; disconnect=1; all other outputs 0; buffer contents undefined.
- Only cycles with sbrx_valid=1 advance framing. tdisconnect has priority in every state and over a simultaneous tconnect: next state is DISCONNECT, the frame is silently dropped, and no trans_error is raised.
- Symbols: DLE=0xFE, STX_CMD=0x05, STX_RSP=0x04, ETX=0x40, LSE=0xA0, CLSE=0x5F.
- State transitions:
  - DISCONNECT -> IDLE on tconnect; disconnect drops to 0 the cycle after.
  - IDLE -> DLE1 on DLE; other bytes are ignored.
  - DLE1:
    - STX_CMD/STX_RSP -> BODY; captures kind, clears the byte counter, initialises CRC to 0xFFFF and folds the STX byte in.
    - LSE -> LT.
    - DLE -> stays in DLE1.
    - Anything else -> IDLE, no error.
  - LT: CLSE -> IDLE with lt_valid pulse. Any other byte -> IDLE with trans_error.
  - BODY:
    - DLE -> ESC.
    - Any other byte is stored as body byte N, where N = byte counter.
  - ESC:
    - DLE -> store 0xFE as a body byte, return to BODY.
    - ETX -> end of frame, evaluate.
    - STX_CMD/STX_RSP -> trans_error, then restart a new frame (resync) in BODY.
    - Anything else -> trans_error, IDLE.
- Body layout:
  - byte0 = address.
  - byte1 = len byte.
  - bytes 2..2+D-1 = data, written to buffer[0..D-1].
  - last two bytes = CRC, low byte first.
- CRC-16: polynomial 0x8005, init 0xFFFF, LSB-first bit order, over STX, address, len and data bytes (unstuffed values).
- Expected data count D: D = t_len if (cmd & WnR) or (rsp & !WnR); otherwise D = 0.
- Errors, each giving a trans_error pulse and a return to IDLE:
  - sbrx_error on any valid byte outside DISCONNECT/IDLE.
  - Byte counter exceeding MAX_DATA_BYTES+4 (overflow).
  - t_len > MAX_DATA_BYTES, checked when the len byte arrives.
  - At ETX: byte count != D+4, or CRC mismatch.
- Accept: t_valid pulses the cycle after the ETX byte. t_is_cmd, t_write, t_address and t_len are registered at that point and held until the next accepted frame. Buffer bytes are valid from t_valid until the next STX is accepted.
- Errors never update the held fields. trans_error and t_valid never assert together.
- Counter saturates, never wraps; a frame of exactly MAX_DATA_BYTES data bytes is legal.

Optional Feature:
- SB_CRC_CHECK_EN defined: CRC-16 is computed and compared at ETX; mismatch gives trans_error.
- Undefined: no CRC logic. The two CRC bytes are still counted and discarded, and a CRC mismatch is never flagged; length checks remain.

Test Plan:
- tconnect, then FE 05 12 83 AA FE FE BB crcL crcH FE 40 with correct CRC -> t_valid=1 one cycle, t_is_cmd=1, t_write=1, t_address=0x12, t_len=3, rd_data[0..2]=AA,FE,BB; trans_error=0.
- Same frame with crcL bit0 flipped -> trans_error one cycle, no t_valid, held fields unchanged. Without SB_CRC_CHECK_EN -> t_valid.
- FE A0 5F -> lt_valid one cycle. FE A0 12 -> trans_error, state IDLE.
- Read command FE 05 20 04 crcL crcH FE 40 (D=0) -> t_valid, t_write=0, t_len=4. Same frame with one extra data byte -> trans_error.
- tdisconnect asserted mid-BODY together with tconnect -> disconnect=1 next cycle, no trans_error, no t_valid; a later tconnect plus a valid frame decodes correctly.
- Write command with len=MAX_DATA_BYTES+1 -> trans_error on the len byte. Len=MAX_DATA_BYTES with full data -> t_valid.

Source files
------------

// File: rtl/sb_trans_deframer.sv
// Sideband receive deframer: DLE-framed AT command/response and LT frames.
// Optional CRC-16 checking is compiled in with `define SB_CRC_CHECK_EN.
module sb_trans_deframer #(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned IDX_W          = 7
) (
  input  logic              sb_clk,
  input  logic              rst,
  input  logic              sbrx_valid,
  input  logic [7:0]        sbrx_data,
  input  logic              sbrx_error,
  input  logic              tconnect,
  input  logic              tdisconnect,
  output logic              t_valid,
  output logic              t_is_cmd,
  output logic              t_write,
  output logic [ADDR_W-1:0] t_address,
  output logic [6:0]        t_len,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [7:0]        rd_data,
  output logic              lt_valid,
  output logic              trans_error,
  output logic              disconnect
);

  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;
  localparam logic [7:0] LSE     = 8'hA0;
  localparam logic [7:0] CLSE    = 8'h5F;

  localparam logic [7:0]  MAX_B   = 8'(MAX_DATA_BYTES);
  localparam logic [7:0]  CNT_MAX = 8'(MAX_DATA_BYTES + 4);
  localparam int unsigned AW      = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;

  typedef enum logic [2:0] {
    S_DISCONNECT,
    S_IDLE,
    S_DLE1,
    S_LT,
    S_BODY,
    S_ESC
  } state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       kind, kind_nx;
  logic [7:0] addr, addr_nx;
  logic [7:0] len_b, len_nx;
  logic [7:0] d_exp;
  logic       crc_ok;
  logic       start, store;
  logic       acc, lt_p, err_p;
  logic       wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0] mem [2**AW];

`ifdef SB_CRC_CHECK_EN
  logic [15:0] crc, crc_nx;
  logic [15:0] crc_win, crc_win_nx;

  // Reflected form of polynomial 0x8005, bytes consumed LSB first.
  function automatic logic [15:0] crc_fold(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  assign crc_ok = (crc == crc_win);
`else
  assign crc_ok = 1'b1;
`endif

  assign d_exp      = (kind == len_b[7]) ? {1'b0, len_b[6:0]} : 8'd0;
  assign disconnect = (state == S_DISCONNECT);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    kind_nx  = kind;
    addr_nx  = addr;
    len_nx   = len_b;
`ifdef SB_CRC_CHECK_EN
    crc_nx     = crc;
    crc_win_nx = crc_win;
`endif
    start  = 1'b0;
    store  = 1'b0;
    acc    = 1'b0;
    lt_p   = 1'b0;
    err_p  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = '0;

    if (tdisconnect) begin
      state_nx = S_DISCONNECT;
    end else if (state == S_DISCONNECT) begin
      if (tconnect) state_nx = S_IDLE;
    end else if (sbrx_valid) begin
      if (sbrx_error && state != S_IDLE) begin
        err_p    = 1'b1;
        state_nx = S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (sbrx_data == DLE) state_nx = S_DLE1;
          S_DLE1: begin
            if (sbrx_data == STX_CMD || sbrx_data == STX_RSP) begin
              start    = 1'b1;
              state_nx = S_BODY;
            end else if (sbrx_data == LSE) state_nx = S_LT;
            else if (sbrx_data != DLE)     state_nx = S_IDLE;
          end
          S_LT: begin
            state_nx = S_IDLE;
            if (sbrx_data == CLSE) lt_p = 1'b1;
            else                   err_p = 1'b1;
          end
          S_BODY: begin
            if (sbrx_data == DLE) state_nx = S_ESC;
            else                  store = 1'b1;
          end
          S_ESC: begin
            if (sbrx_data == DLE) begin
              store    = 1'b1;
              state_nx = S_BODY;
            end else if (sbrx_data == ETX) begin
              state_nx = S_IDLE;
              if (cnt == d_exp + 8'd4 && crc_ok) acc = 1'b1;
              else                               err_p = 1'b1;
            end else if (sbrx_data == STX_CMD || sbrx_data == STX_RSP) begin
              err_p    = 1'b1;
              start    = 1'b1;
              state_nx = S_BODY;
            end else begin
              err_p    = 1'b1;
              state_nx = S_IDLE;
            end
          end
          default: state_nx = S_IDLE;
        endcase
      end
    end

    if (start) begin
      kind_nx = (sbrx_data == STX_CMD);
      cnt_nx  = '0;
`ifdef SB_CRC_CHECK_EN
      crc_nx  = crc_fold(16'hFFFF, sbrx_data);
`endif
    end

    // Escaped DLE reaches here with sbrx_data already equal to 0xFE.
    if (store) begin
      if (cnt == CNT_MAX) begin
        err_p    = 1'b1;
        state_nx = S_IDLE;
      end else if (cnt == 8'd1 && {1'b0, sbrx_data[6:0]} > MAX_B) begin
        err_p    = 1'b1;
        state_nx = S_IDLE;
      end else begin
        cnt_nx = cnt + 8'd1;
        if (cnt == 8'd0) addr_nx = sbrx_data;
        if (cnt == 8'd1) len_nx  = sbrx_data;
`ifdef SB_CRC_CHECK_EN
        crc_win_nx = {sbrx_data, crc_win[15:8]};
        if (cnt < 8'd2 || cnt < d_exp + 8'd2) crc_nx = crc_fold(crc, sbrx_data);
`endif
        if (cnt >= 8'd2 && (cnt - 8'd2) < MAX_B) begin
          wr_en  = 1'b1;
          wr_idx = AW'(cnt - 8'd2);
        end
      end
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state       <= S_DISCONNECT;
      cnt         <= '0;
      kind        <= 1'b0;
      addr        <= '0;
      len_b       <= '0;
`ifdef SB_CRC_CHECK_EN
      crc         <= '1;
      crc_win     <= '0;
`endif
      t_valid     <= 1'b0;
      t_is_cmd    <= 1'b0;
      t_write     <= 1'b0;
      t_address   <= '0;
      t_len       <= '0;
      lt_valid    <= 1'b0;
      trans_error <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      kind        <= kind_nx;
      addr        <= addr_nx;
      len_b       <= len_nx;
`ifdef SB_CRC_CHECK_EN
      crc         <= crc_nx;
      crc_win     <= crc_win_nx;
`endif
      t_valid     <= acc;
      lt_valid    <= lt_p;
      trans_error <= err_p;
      if (acc) begin
        t_is_cmd  <= kind;
        t_write   <= len_b[7];
        t_address <= ADDR_W'(addr);
        t_len     <= len_b[6:0];
      end
    end
  end

  always_ff @(posedge sb_clk) begin
    if (wr_en) mem[wr_idx] <= sbrx_data;
  end

  assign rd_data = (32'(rd_idx) < MAX_DATA_BYTES) ? mem[rd_idx[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_sb_trans_deframer.sv
// Directed self-checking bench for sb_trans_deframer (default parameters).
// CRC bytes come from an independent bitwise CRC-16 model.
module tb_sb_trans_deframer;

  localparam int MAXD = 64;

  logic       sb_clk = 1'b0;
  logic       rst;
  logic       sbrx_valid, sbrx_error, tconnect, tdisconnect;
  logic [7:0] sbrx_data;
  logic       t_valid, t_is_cmd, t_write, lt_valid, trans_error, disconnect;
  logic [7:0] t_address;
  logic [6:0] t_len;
  logic [6:0] rd_idx;
  logic [7:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] dat [128];

  sb_trans_deframer #(.MAX_DATA_BYTES(MAXD), .ADDR_W(8), .IDX_W(7)) dut (
    .sb_clk(sb_clk), .rst(rst),
    .sbrx_valid(sbrx_valid), .sbrx_data(sbrx_data), .sbrx_error(sbrx_error),
    .tconnect(tconnect), .tdisconnect(tdisconnect),
    .t_valid(t_valid), .t_is_cmd(t_is_cmd), .t_write(t_write),
    .t_address(t_address), .t_len(t_len),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .lt_valid(lt_valid), .trans_error(trans_error), .disconnect(disconnect)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-bit LFSR view of CRC-16 (0x8005 reflected), input bits LSB first.
  function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    sbrx_data  = b;
    sbrx_valid = 1'b1;
    sbrx_error = err;
    tick();
    sbrx_valid = 1'b0;
    sbrx_error = 1'b0;
  endtask

  task automatic send_body(input logic [7:0] b);
    send(b);
    if (b == 8'hFE) send(b);
  endtask

  task automatic connect();
    tconnect = 1'b1;
    tick();
    tconnect = 1'b0;
  endtask

  // Sends [FE STX] addr len dat[0..nd-1] crcL crcH FE 40, stuffing 0xFE.
  task automatic send_frame(input logic cmd, input logic [7:0] a, input logic [7:0] lenb,
                            input int nd, input logic bad, input logic hdr);
    logic [15:0] c;
    logic [7:0]  stx;
    stx = cmd ? 8'h05 : 8'h04;
    c = crc_bits(16'hFFFF, stx);
    c = crc_bits(c, a);
    c = crc_bits(c, lenb);
    for (int i = 0; i < nd; i++) c = crc_bits(c, dat[i]);
    if (bad) c[0] = ~c[0];
    if (hdr) begin
      send(8'hFE);
      send(stx);
    end
    send_body(a);
    send_body(lenb);
    for (int i = 0; i < nd; i++) send_body(dat[i]);
    send_body(c[7:0]);
    send_body(c[15:8]);
    send(8'hFE);
    send(8'h40);
  endtask

  task automatic rd_check(input string tag, input logic [6:0] idx, input logic [7:0] exp);
    rd_idx = idx;
    #1;
    check(tag, rd_data, exp);
  endtask

  initial begin
    rst = 1'b0; sbrx_valid = 1'b0; sbrx_error = 1'b0; sbrx_data = '0;
    tconnect = 1'b0; tdisconnect = 1'b0; rd_idx = '0;
    tick(); tick();
    check("rst_disconnect", disconnect, 1);
    check("rst_t_valid", t_valid, 0);
    check("rst_trans_error", trans_error, 0);
    check("rst_lt_valid", lt_valid, 0);
    check("rst_t_address", t_address, 0);
    check("rst_t_len", t_len, 0);
    #2 rst = 1'b1;
    tick();

    connect();
    check("connect_disconnect", disconnect, 0);

    // Write command, escaped FE in data
    dat[0] = 8'hAA; dat[1] = 8'hFE; dat[2] = 8'hBB;
    send_frame(1, 8'h12, 8'h83, 3, 0, 1);
    check("wr_t_valid", t_valid, 1);
    check("wr_trans_error", trans_error, 0);
    check("wr_is_cmd", t_is_cmd, 1);
    check("wr_write", t_write, 1);
    check("wr_addr", t_address, 8'h12);
    check("wr_len", t_len, 3);
    rd_check("wr_rd0", 0, 8'hAA);
    rd_check("wr_rd1", 1, 8'hFE);
    rd_check("wr_rd2", 2, 8'hBB);
    tick();
    check("wr_t_valid_pulse", t_valid, 0);

    // Corrupted CRC
    send_frame(1, 8'h12, 8'h83, 3, 1, 1);
`ifdef SB_CRC_CHECK_EN
    check("badcrc_trans_error", trans_error, 1);
    check("badcrc_t_valid", t_valid, 0);
`else
    check("badcrc_t_valid", t_valid, 1);
    check("badcrc_trans_error", trans_error, 0);
`endif
    check("badcrc_addr", t_address, 8'h12);
    tick();
    check("badcrc_err_pulse", trans_error, 0);

    // LT frames
    send(8'hFE); send(8'hA0); send(8'h5F);
    check("lt_valid", lt_valid, 1);
    check("lt_no_err", trans_error, 0);
    tick();
    check("lt_pulse", lt_valid, 0);
    send(8'hFE); send(8'hA0); send(8'h12);
    check("lt_bad_err", trans_error, 1);
    check("lt_bad_valid", lt_valid, 0);

    // Read command, D=0
    send_frame(1, 8'h20, 8'h04, 0, 0, 1);
    check("rd_t_valid", t_valid, 1);
    check("rd_write", t_write, 0);
    check("rd_len", t_len, 4);
    check("rd_addr", t_address, 8'h20);

    // Read command carrying an unexpected data byte
    dat[0] = 8'h99;
    send_frame(1, 8'h31, 8'h04, 1, 0, 1);
    check("rdx_trans_error", trans_error, 1);
    check("rdx_t_valid", t_valid, 0);
    check("rdx_hold_addr", t_address, 8'h20);
    check("rdx_hold_len", t_len, 4);

    // Read response with data
    dat[0] = 8'h11; dat[1] = 8'h22;
    send_frame(0, 8'h07, 8'h02, 2, 0, 1);
    check("rsp_t_valid", t_valid, 1);
    check("rsp_is_cmd", t_is_cmd, 0);
    check("rsp_write", t_write, 0);
    check("rsp_len", t_len, 2);
    rd_check("rsp_rd1", 1, 8'h22);

    // Disconnect mid-body, simultaneous with connect
    send(8'hFE); send(8'h05); send(8'h33);
    tdisconnect = 1'b1; tconnect = 1'b1;
    tick();
    tdisconnect = 1'b0; tconnect = 1'b0;
    check("disc_level", disconnect, 1);
    check("disc_no_err", trans_error, 0);
    check("disc_no_valid", t_valid, 0);
    send(8'hFE); send(8'h40);
    check("disc_ignored", t_valid | trans_error, 0);
    connect();
    dat[0] = 8'h5A;
    send_frame(1, 8'h44, 8'h81, 1, 0, 1);
    check("reconn_t_valid", t_valid, 1);
    check("reconn_addr", t_address, 8'h44);

    // Length MAX+1 rejected on the len byte
    send(8'hFE); send(8'h05); send(8'h55);
    check("len65_pre", trans_error, 0);
    send(8'hC1);
    check("len65_err", trans_error, 1);
    check("len65_hold_addr", t_address, 8'h44);

    // Exactly MAX data bytes
    for (int i = 0; i < MAXD; i++) dat[i] = 8'(i);
    send_frame(1, 8'h66, 8'hC0, MAXD, 0, 1);
    check("full_t_valid", t_valid, 1);
    check("full_len", t_len, 7'd64);
    rd_check("full_rd0", 0, 8'h00);
    rd_check("full_rd63", 63, 8'h3F);

    // STX inside escape: error then resync into a new frame
    send(8'hFE); send(8'h05); send(8'h66);
    send(8'hFE); send(8'h05);
    check("resync_err", trans_error, 1);
    dat[0] = 8'h10;
    send_frame(1, 8'h77, 8'h81, 1, 0, 0);
    check("resync_t_valid", t_valid, 1);
    check("resync_addr", t_address, 8'h77);

    // Symbol error mid-body
    send(8'hFE); send(8'h05); send(8'h12);
    send(8'h34, 1'b1);
    check("symerr_err", trans_error, 1);

    // Counter overflow: 68 body bytes allowed, 69th aborts
    send(8'hFE); send(8'h05); send(8'h01); send(8'h04);
    for (int i = 0; i < 66; i++) send(8'h01);
    check("ovf_at_limit", trans_error, 0);
    send(8'h01);
    check("ovf_err", trans_error, 1);
    check("ovf_no_valid", t_valid, 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
